// File: rtl/sgdh_switch_conditioner_pkg.sv
// Shared encodings and helpers for the switch conditioner and its neighbours.
package sgdh_switch_conditioner_pkg;

  typedef enum logic [1:0] {
    S_REL   = 2'd0,
    S_CHK_P = 2'd1,
    S_PRS   = 2'd2,
    S_CHK_R = 2'd3
  } state_t;

  localparam int MODE_TOGGLE = 0;
  localparam int MODE_LEVEL  = 1;
  localparam int CLK_FREQ_HZ = 125000000;

  // Counter only has to reach n-1, so $clog2(n) bits suffice (min 1).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sgdh_sync_2ff.sv
// Two-flop synchronizer for one asynchronous board input; clears to 0 on reset.
module sgdh_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/sgdh_switch_conditioner.sv
// Raw button -> synchronizer -> debounce FSM -> toggle/level enable plus press strobe.
module sgdh_switch_conditioner
  import sgdh_switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int MODE            = 0,
  parameter bit INIT_EN         = 1'b0
) (
  input  logic clk,
  input  logic areset,
  input  logic btn_raw,
  output logic switch_en,
  output logic press_pulse,
  output logic btn_stable
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_d, stable_d, en_d;

  sgdh_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (areset),
    .d     (btn_raw),
    .q     (s2)
  );

  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q     <= S_REL;
      cnt_q       <= '0;
      press_pulse <= 1'b0;
      btn_stable  <= 1'b0;
      switch_en   <= INIT_EN;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_pulse <= pulse_d;
      btn_stable  <= stable_d;
      switch_en   <= en_d;
    end
  end

  // Counter only increments below CNT_MAX, so it can never wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    stable_d = btn_stable;
    en_d     = switch_en;
    case (state_q)
      S_REL: begin
        if (s2) begin
          state_d = S_CHK_P;
          cnt_d   = '0;
        end
      end
      S_CHK_P: begin
        if (!s2) begin
          state_d = S_REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = S_PRS;
          stable_d = 1'b1;
          pulse_d  = 1'b1;
          en_d     = (MODE == MODE_LEVEL) ? 1'b1 : ~switch_en;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRS: begin
        if (!s2) begin
          state_d = S_CHK_R;
          cnt_d   = '0;
        end
      end
      S_CHK_R: begin
        if (s2) begin
          state_d = S_PRS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = S_REL;
          stable_d = 1'b0;
          if (MODE == MODE_LEVEL) en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_REL;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sgdh_switch_conditioner.sv
// Directed bench: three conditioner flavours (toggle/D=4, level/D=4, toggle/D=1/INIT_EN=1).
module tb_sgdh_switch_conditioner;

  logic       clk = 1'b0;
  logic [2:0] rst_n = 3'b000;
  logic [2:0] btn = 3'b000;
  logic [2:0] en, pp, st;
  int         n_chk = 0;
  int         n_fail = 0;

  always #4 clk = ~clk;

  sgdh_switch_conditioner #(.DEBOUNCE_CYCLES(4), .MODE(0), .INIT_EN(1'b0)) u_tog (
    .clk(clk), .areset(rst_n[0]), .btn_raw(btn[0]),
    .switch_en(en[0]), .press_pulse(pp[0]), .btn_stable(st[0]));

  sgdh_switch_conditioner #(.DEBOUNCE_CYCLES(4), .MODE(1), .INIT_EN(1'b0)) u_lvl (
    .clk(clk), .areset(rst_n[1]), .btn_raw(btn[1]),
    .switch_en(en[1]), .press_pulse(pp[1]), .btn_stable(st[1]));

  sgdh_switch_conditioner #(.DEBOUNCE_CYCLES(1), .MODE(0), .INIT_EN(1'b1)) u_d1 (
    .clk(clk), .areset(rst_n[2]), .btn_raw(btn[2]),
    .switch_en(en[2]), .press_pulse(pp[2]), .btn_stable(st[2]));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n ticks on instance k; reports pulse count and 1-based tick of first pulse /
  // first btn_stable change / first switch_en change (0 if none).
  task automatic run(input int k, input int n, output int npulse, output int fp,
                     output int fst, output int fen);
    logic st0, en0;
    st0 = st[k]; en0 = en[k];
    npulse = 0; fp = 0; fst = 0; fen = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (pp[k]) begin
        npulse++;
        if (fp == 0) fp = i;
      end
      if (fst == 0 && st[k] != st0) fst = i;
      if (fen == 0 && en[k] != en0) fen = i;
    end
  endtask

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    btn[k]   = 1'b0;
    tick(); tick();
    rst_n[k] = 1'b1;
  endtask

  int np, fp, fst, fen, tot;

  initial begin
    // 1. reset with button held, then held through deassertion
    rst_n = 3'b000; btn = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_en", en[0], 0);
      chk("rst_pulse", pp[0], 0);
      chk("rst_stable", st[0], 0);
    end
    chk("rst_init_en1", en[2], 1);
    rst_n[0] = 1'b1;
    run(0, 8, np, fp, fst, fen);
    chk("held_rst_npulse", np, 1);
    chk("held_rst_pulse_edge", fp, 7);
    chk("held_rst_en_edge", fen, 7);
    chk("held_rst_en", en[0], 1);

    // 2. clean presses, toggle mode
    do_reset(0);
    chk("p1_pre_en", en[0], 0);
    btn[0] = 1'b1;
    run(0, 20, np, fp, fst, fen);
    chk("p1_npulse", np, 1);
    chk("p1_pulse_edge", fp, 7);
    chk("p1_stable_edge", fst, 7);
    chk("p1_en", en[0], 1);
    btn[0] = 1'b0;
    run(0, 10, np, fp, fst, fen);
    chk("r1_npulse", np, 0);
    chk("r1_stable_fall_edge", fst, 7);
    chk("r1_en_hold", en[0], 1);
    btn[0] = 1'b1;
    run(0, 20, np, fp, fst, fen);
    chk("p2_npulse", np, 1);
    chk("p2_pulse_edge", fp, 7);
    chk("p2_en", en[0], 0);
    btn[0] = 1'b0;
    run(0, 10, np, fp, fst, fen);
    chk("r2_stable", st[0], 0);

    // 3. bounce rejection, then a clean press must see full latency again
    do_reset(0);
    tot = 0;
    begin
      logic [8:0] pat;
      pat = 9'b0_1011_0111; // applied LSB first: 1,1,1,0,1,1,0,1,0
      for (int i = 0; i < 9; i++) begin
        btn[0] = pat[i];
        run(0, 1, np, fp, fst, fen);
        tot += np;
      end
    end
    run(0, 10, np, fp, fst, fen);
    tot += np;
    chk("bounce_npulse", tot, 0);
    chk("bounce_en", en[0], 0);
    chk("bounce_stable", st[0], 0);
    btn[0] = 1'b1;
    run(0, 10, np, fp, fst, fen);
    chk("post_bounce_pulse_edge", fp, 7);
    btn[0] = 1'b0;

    // 4. level mode
    do_reset(1);
    btn[1] = 1'b1;
    run(1, 10, np, fp, fst, fen);
    chk("lvl_npulse", np, 1);
    chk("lvl_pulse_edge", fp, 7);
    chk("lvl_rise_edge", fen, 7);
    chk("lvl_en_hi", en[1], 1);
    btn[1] = 1'b0;
    run(1, 10, np, fp, fst, fen);
    chk("lvl_rel_npulse", np, 0);
    chk("lvl_fall_edge", fen, 7);
    chk("lvl_en_lo", en[1], 0);

    // 5. reset in the middle of the count
    do_reset(0);
    btn[0] = 1'b1;
    run(0, 5, np, fp, fst, fen);
    tot = np;
    rst_n[0] = 1'b0;
    run(0, 2, np, fp, fst, fen);
    tot += np;
    chk("midrst_en", en[0], 0);
    chk("midrst_stable", st[0], 0);
    btn[0] = 1'b0; rst_n[0] = 1'b1;
    run(0, 10, np, fp, fst, fen);
    tot += np;
    chk("midrst_npulse", tot, 0);
    chk("midrst_en_after", en[0], 0);

    // 6. DEBOUNCE_CYCLES=1, INIT_EN=1, 2-cycle press
    do_reset(2);
    chk("d1_init_en", en[2], 1);
    btn[2] = 1'b1;
    run(2, 2, np, fp, fst, fen);
    chk("d1_early_npulse", np, 0);
    btn[2] = 1'b0;
    run(2, 10, np, fp, fst, fen);
    chk("d1_npulse", np, 1);
    chk("d1_pulse_edge", fp, 2);
    chk("d1_en", en[2], 0);
    chk("d1_stable", st[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sgdh_switch_conditioner.md
Name: sgdh_switch_conditioner

Overview:
Conditions one raw board push-button or slide switch into a clean `switch_en` level for one traffic-light core.
- Sits directly upstream of the traffic-light top. Two instances drive `switch_en_c0` and `switch_en_c1`.
- Datapath: 2-flop synchronizer, then debounce FSM with cycle counter, then toggle/level output stage.
- Also emits a single-cycle `press_pulse` per accepted press, for event logging.

Parameters:
- DEBOUNCE_CYCLES, default 1250000, stable-input cycles required to accept an edge (10 ms at 125 MHz); legal range >= 1.
- MODE, default 0, output mode. 0 = TOGGLE: `switch_en` flips on each accepted press. 1 = LEVEL: `switch_en` follows the debounced input.
- INIT_EN, default 0, reset value of `switch_en`.

Ports:
- clk  input  1  system clock, 125 MHz.
- areset  input  1  synchronous, active-low reset, sampled on rising `clk`.
- btn_raw  input  1  asynchronous raw button/switch, active-high.
- switch_en  output  1  conditioned enable to the traffic-light core.
- press_pulse  output  1  one-cycle strobe per accepted press.
- btn_stable  output  1  current debounced level.

Behaviour:
- All state changes occur on rising `clk`. Reset acts only at a clock edge where `areset`=0.
- Reset values:
  - sync flops s1, s2 = 0
  - state = S_REL, cnt = 0
  - press_pulse = 0, btn_stable = 0
  - switch_en = INIT_EN
- Synchronizer: s1 <= btn_raw; s2 <= s1. The FSM uses only s2.
- Counter: width CNT_W = max(1, $clog2(DEBOUNCE_CYCLES)). It never wraps and saturates at DEBOUNCE_CYCLES-1.
- FSM states and transitions:
  - S_REL: s2=1 -> S_CHK_P, cnt<=0. Otherwise stay.
  - S_CHK_P:
    - s2=0 -> S_REL, cnt<=0 (glitch rejected, no output change).
    - s2=1 and cnt==DEBOUNCE_CYCLES-1 -> S_PRS; btn_stable<=1; press_pulse<=1; switch_en<=~switch_en (MODE 0) or 1 (MODE 1).
    - else cnt<=cnt+1.
  - S_PRS: s2=0 -> S_CHK_R, cnt<=0. Otherwise stay.
  - S_CHK_R:
    - s2=1 -> S_PRS, cnt<=0.
    - s2=0 and cnt==DEBOUNCE_CYCLES-1 -> S_REL; btn_stable<=0; switch_en<=0 in MODE 1, unchanged in MODE 0.
    - else cnt<=cnt+1.
- press_pulse is registered and high for exactly one cycle. It is never asserted on release.
- Latency: btn_raw high and stable from the cycle before edge 1 gives press_pulse, btn_stable and switch_en updating at edge DEBOUNCE_CYCLES+3. That is 2 sync edges, 1 edge into S_CHK_P, and DEBOUNCE_CYCLES counting edges. Release latency is the same.
- Boundaries:
  - Bounce shorter than DEBOUNCE_CYCLES consecutive s2-high cycles: no output change, FSM returns to S_REL.
  - DEBOUNCE_CYCLES=1: edge accepted at the first edge in the CHK state.
  - Button held through reset deassertion: treated as a new press. After the full latency it is accepted, with a pulse and a toggle.
  - Reset mid-count or in S_PRS: immediate return to reset values. No pulse is generated on reset.
  - Held button: exactly one press_pulse and one toggle, regardless of hold length.
- No combinational path from btn_raw to any output. All outputs are registers.

Decomposition:
- common_defines.vh, shared:
  - FSM state encodings S_REL, S_CHK_P, S_PRS, S_CHK_R as 2-bit localparams.
  - MODE_TOGGLE=0 and MODE_LEVEL=1.
  - CLK_FREQ_HZ=125000000.
- Sub-module sgdh_sync_2ff (1-bit, reset value 0). It is reused elsewhere for all asynchronous board inputs.
- The traffic-light top instantiates two sgdh_switch_conditioner ahead of its cores.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and INIT_EN=0 unless noted.
1. Reset: hold areset=0 for 3 clk with btn_raw=1 -> switch_en=0, press_pulse=0, btn_stable=0 throughout. Then release reset with btn_raw still 1 -> press_pulse high on edge 7 after release; switch_en=1.
2. Clean press, MODE 0: btn_raw 0->1 held 20 cycles, then 0 -> press_pulse high exactly 1 cycle at edge 7; switch_en 0->1; btn_stable falls 7 edges after release; switch_en stays 1. Second identical press -> switch_en=0.
3. Bounce rejection: btn_raw pattern 1,1,1,0,1,1,0,1 then 0 -> no press_pulse, switch_en unchanged, FSM back in S_REL.
4. MODE 1: press held 10 cycles, then release -> switch_en=1 at edge 7 after press, =0 at edge 7 after release; exactly one press_pulse.
5. Reset mid-count: press; assert areset=0 at edge 5 (cnt=2) -> outputs at reset values; no pulse seen before or after reset.
6. DEBOUNCE_CYCLES=1, INIT_EN=1: single 2-cycle press -> press_pulse at edge 4; switch_en 1->0.
